// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned REQ_IFETCH = 0;
    localparam int unsigned REQ_DATA   = 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

    typedef enum logic {
        StEmpty,
        StFull
    } resp_state_e;

    // Word index beyond the configured memory depth.
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input int unsigned words);
        return {2'b00, addr[31:2]} >= words;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] eligible_i,
    output logic [1:0] grant_o
);

    logic last_q, last_d;

    always_comb begin
        grant_o = 2'b00;
        unique case (eligible_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase

        // A grant is always an accept: eligibility already includes valid and room.
        last_d = last_q;
        if (grant_o[0]) begin
            last_d = 1'b0;
        end else if (grant_o[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requesters onto one combinational memory port.
// Optional address range checking is enabled by defining MEM_ARB_RANGE_CHECK_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEMORY_WORDS = 65536,
    parameter int unsigned N_REQ        = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ-1:0]        req_we_i,
    input  logic [N_REQ-1:0][31:0]  req_addr_i,
    input  logic [N_REQ-1:0][31:0]  req_wdata_i,
    output logic [N_REQ-1:0]        resp_valid_o,
    input  logic [N_REQ-1:0]        resp_ready_i,
    output logic [N_REQ-1:0][31:0]  resp_rdata_o,
    output logic [N_REQ-1:0]        resp_err_o,
    output logic [31:0]             mem_ra_o,
    input  logic [31:0]             mem_rd_i,
    output logic                    mem_we_o,
    output logic [31:0]             mem_wa_o,
    output logic [31:0]             mem_wd_o
);

    if (N_REQ != 2) begin : g_bad_n_req
        $error("mem_arbiter: N_REQ must be 2");
    end
    if (MEMORY_WORDS == 0) begin : g_bad_depth
        $error("mem_arbiter: MEMORY_WORDS must be non-zero");
    end

    mem_req_t    req      [N_REQ];
    resp_state_e state_q  [N_REQ];
    resp_state_e state_d  [N_REQ];
    mem_resp_t   resp_q   [N_REQ];
    mem_resp_t   resp_d   [N_REQ];

    logic [1:0]  eligible;
    logic [1:0]  grant;
    logic        any_grant;
    logic        gidx;
    mem_req_t    sel;
    logic        sel_err;
    mem_resp_t   new_resp;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req[i].we    = req_we_i[i];
            req[i].addr  = req_addr_i[i];
            req[i].wdata = req_wdata_i[i];
            // Gated by reset so nothing is granted (and no write issued) while in reset.
            eligible[i]  = rst_ni && req_valid_i[i] &&
                           ((state_q[i] == StEmpty) || resp_ready_i[i]);
        end
    end

    rr_arb2 u_rr_arb2 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .eligible_i (eligible),
        .grant_o    (grant)
    );

    assign req_ready_o = grant;
    assign any_grant   = grant[REQ_IFETCH] | grant[REQ_DATA];
    assign gidx        = grant[REQ_DATA];
    assign sel         = req[gidx];

`ifdef MEM_ARB_RANGE_CHECK_EN
    assign sel_err = any_grant && addr_out_of_range(sel.addr, MEMORY_WORDS);
`else
    assign sel_err = 1'b0;
`endif

    always_comb begin
        mem_ra_o = '0;
        mem_we_o = 1'b0;
        mem_wa_o = '0;
        mem_wd_o = '0;
        if (any_grant) begin
            if (sel.we) begin
                mem_we_o = !sel_err;
                mem_wa_o = sel.addr;
                mem_wd_o = sel.wdata;
            end else begin
                mem_ra_o = sel.addr;
            end
        end
        new_resp.rdata = (sel.we || sel_err) ? 32'd0 : mem_rd_i;
        new_resp.err   = sel_err;
    end

    // Per-requester response slot: an accept in the consume cycle refills without a bubble.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            state_d[i] = state_q[i];
            resp_d[i]  = resp_q[i];
            unique case (state_q[i])
                StEmpty: begin
                    if (grant[i]) begin
                        state_d[i] = StFull;
                        resp_d[i]  = new_resp;
                    end
                end
                StFull: begin
                    if (grant[i]) begin
                        state_d[i] = StFull;
                        resp_d[i]  = new_resp;
                    end else if (resp_ready_i[i]) begin
                        state_d[i] = StEmpty;
                    end
                end
                default: state_d[i] = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_REQ; i++) begin
                state_q[i] <= StEmpty;
                resp_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                state_q[i] <= state_d[i];
                resp_q[i]  <= resp_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            resp_valid_o[i] = (state_q[i] == StFull);
            resp_rdata_o[i] = resp_q[i].rdata;
            resp_err_o[i]   = resp_q[i].err;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [1:0][31:0] req_addr, req_wdata, resp_rdata;
    logic [31:0]      mem_ra, mem_rd, mem_wa, mem_wd;
    logic             mem_we;

    mem_arbiter #(
        .MEMORY_WORDS (65536),
        .N_REQ        (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_ra_o     (mem_ra),
        .mem_rd_i     (mem_rd),
        .mem_we_o     (mem_we),
        .mem_wa_o     (mem_wa),
        .mem_wd_o     (mem_wd)
    );

    // Physical memory: 256 words, writes outside that window are ignored.
    logic [31:0] mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_a  = '0;
    logic [31:0] pre_d  = '0;
    assign mem_rd = mem[mem_ra[9:2]];
    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (mem_we && mem_wa[31:10] == 22'd0) mem[mem_wa[9:2]] <= mem_wd;
    end

    // Reference model state.
    logic [31:0] gold [256];
    bit          m_full [2];
    logic [31:0] m_rdata [2];
    bit          m_err [2];
    bit          m_last;
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  obs_ready;
    int          dut_consumed [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic bit model_oor(input logic [31:0] addr);
`ifdef MEM_ARB_RANGE_CHECK_EN
        return addr[31:18] != 14'd0;
`else
        return (addr != addr) ? 1'b1 : 1'b0;
`endif
    endfunction

    // Inputs are applied at a negedge; check, advance the model, return at the next negedge.
    task automatic step();
        logic [1:0] elig;
        logic [1:0] g;
        int         k;
        bit         e;
        #1;
        for (int i = 0; i < 2; i++) elig[i] = req_valid[i] && (!m_full[i] || resp_ready[i]);
        if (elig == 2'b11) g = m_last ? 2'b01 : 2'b10;
        else g = elig;
        obs_ready = req_ready;
        chk("req_ready", req_ready, g);
        chk("resp_valid", resp_valid, {m_full[1], m_full[0]});
        for (int i = 0; i < 2; i++) begin
            if (m_full[i]) begin
                chk($sformatf("rdata%0d", i), resp_rdata[i], m_rdata[i]);
                chk($sformatf("err%0d", i), resp_err[i], m_err[i]);
            end
        end
        k = g[1] ? 1 : 0;
        e = model_oor(req_addr[k]);
        if (g == 2'b00) begin
            chk("idle_we", mem_we, 0);
            chk("idle_ra", mem_ra, 0);
            chk("idle_wa", mem_wa, 0);
            chk("idle_wd", mem_wd, 0);
        end else if (req_we[k]) begin
            chk("wr_we", mem_we, !e);
            chk("wr_wa", mem_wa, req_addr[k]);
            chk("wr_wd", mem_wd, req_wdata[k]);
        end else begin
            chk("rd_we", mem_we, 0);
            chk("rd_ra", mem_ra, req_addr[k]);
        end
        for (int i = 0; i < 2; i++) begin
            if (resp_valid[i] && resp_ready[i]) dut_consumed[i]++;
            if (m_full[i] && resp_ready[i]) m_full[i] = 0;
        end
        if (g != 2'b00) begin
            m_full[k]  = 1;
            m_err[k]   = e;
            m_rdata[k] = (req_we[k] || e) ? 32'd0 : gold[req_addr[k][9:2]];
            if (req_we[k] && !e && req_addr[k][31:10] == 22'd0)
                gold[req_addr[k][9:2]] = req_wdata[k];
            m_last = (k == 1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0;
            m_rdata[i] = '0;
            m_err[i] = 0;
        end
        m_last = 1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
    endtask

    initial begin
        logic [7:0]  seq;
        logic [31:0] held;
        logic [7:0]  w;
        idle_inputs();
        resp_ready = 2'b11;
        model_reset();
        dut_consumed[0] = 0;
        dut_consumed[1] = 0;

        // Preload memory and golden copy while in reset.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pre_we = 1'b1;
            pre_a = 8'(i);
            pre_d = (i == 4) ? 32'hDEADBEEF : (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5;
            gold[i] = pre_d;
        end
        @(negedge clk);
        pre_we = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        #1;
        chk("idle_rdata0", resp_rdata[0], 0);
        chk("idle_rdata1", resp_rdata[1], 0);
        chk("idle_err", resp_err, 0);
        step();

        // Single read of 0x10.
        req_valid = 2'b01;
        req_addr[0] = 32'h10;
        step();
        idle_inputs();
        #1;
        chk("rd10_valid", resp_valid, 2'b01);
        chk("rd10_data", resp_rdata[0], 32'hDEADBEEF);
        step();

        // One requester-1 read so the pointer favours requester 0 again.
        req_valid = 2'b10;
        req_addr[1] = 32'h14;
        step();
        idle_inputs();
        step();

        // Both valid for four cycles: alternating grants.
        dut_consumed[0] = 0;
        dut_consumed[1] = 0;
        seq = '0;
        req_valid = 2'b11;
        req_addr[0] = 32'h18;
        req_addr[1] = 32'h1C;
        for (int c = 0; c < 4; c++) begin
            step();
            seq = {seq[5:0], obs_ready};
        end
        idle_inputs();
        step();
        step();
        chk("rr_seq", seq, 8'b01100110);
        chk("rr_cnt0", dut_consumed[0], 2);
        chk("rr_cnt1", dut_consumed[1], 2);

        // Write from requester 1, read back from requester 0.
        req_valid = 2'b10;
        req_we[1] = 1'b1;
        req_addr[1] = 32'h20;
        req_wdata[1] = 32'h12345678;
        step();
        idle_inputs();
        req_valid = 2'b01;
        req_addr[0] = 32'h20;
        step();
        idle_inputs();
        #1;
        chk("wr_rd_data", resp_rdata[0], 32'h12345678);
        step();

        // Requester 0 stalled must not block requester 1.
        req_valid = 2'b01;
        req_addr[0] = 32'h30;
        held = gold[12];
        step();
        resp_ready = 2'b10;
        req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            req_addr[1] = 32'h40 + 32'(c * 4);
            step();
            chk("stall_ready", obs_ready, 2'b10);
            chk("stall_hold", resp_rdata[0], held);
        end
        idle_inputs();
        resp_ready = 2'b11;
        step();
        step();

        // Write to word 65536.
        req_valid = 2'b10;
        req_we[1] = 1'b1;
        req_addr[1] = 32'h40000;
        req_wdata[1] = 32'hCAFEF00D;
        #1;
`ifdef MEM_ARB_RANGE_CHECK_EN
        chk("oor_we", mem_we, 0);
`else
        chk("oor_we", mem_we, 1);
`endif
        step();
        idle_inputs();
        #1;
`ifdef MEM_ARB_RANGE_CHECK_EN
        chk("oor_err", resp_err[1], 1);
`else
        chk("oor_err", resp_err[1], 0);
`endif
        step();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                w = 8'($urandom);
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_we[i] = ($urandom_range(0, 2) == 0);
                req_addr[i] = {22'd0, w, 2'($urandom)};
                req_wdata[i] = $urandom;
                resp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        idle_inputs();
        resp_ready = 2'b11;
        step();
        step();

        // Reset mid-stream with a response held.
        req_valid = 2'b01;
        req_addr[0] = 32'h10;
        resp_ready = 2'b00;
        step();
        chk("pre_rst_valid", resp_valid, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", resp_valid, 0);
        chk("rst_async_we", mem_we, 0);
        chk("rst_async_ready", req_ready, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        resp_ready = 2'b11;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
